// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MEM_WIDTH+2-bit MOSI command frames for the RAM
// and serialises RAM read data back out on MISO, MSB first.
module spi_slave_ctrl #(
  parameter int MEM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [MEM_WIDTH+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int FW = MEM_WIDTH + 2;
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(MEM_WIDTH + 2);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t               state;
  logic [FW-2:0]        rx_shift;
  logic [CW-1:0]        rx_cnt;
  logic [MEM_WIDTH-1:0] tx_shift;
  logic [TW-1:0]        tx_cnt;
  logic                 rd_addr_received;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rx_shift         <= '0;
      rx_cnt           <= '0;
      tx_shift         <= '0;
      tx_cnt           <= '0;
      rd_addr_received <= 1'b0;
      rx_data          <= '0;
      rx_valid         <= 1'b0;
      MISO             <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        state  <= IDLE;
        rx_cnt <= '0;
        tx_cnt <= '0;
        MISO   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state  <= CHK_CMD;
            rx_cnt <= '0;
            tx_cnt <= '0;
            MISO   <= 1'b0;
          end
          CHK_CMD: begin
            rx_shift <= {{(FW-2){1'b0}}, MOSI};
            rx_cnt   <= CW'(1);
            if (!MOSI)                 state <= WRITE;
            else if (!rd_addr_received) state <= READ_ADD;
            else                       state <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (rx_cnt < CW'(FW)) begin
              rx_shift <= {rx_shift[FW-3:0], MOSI};
              rx_cnt   <= rx_cnt + CW'(1);
              if (rx_cnt == CW'(FW - 1)) begin
                rx_data  <= {rx_shift, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD)  rd_addr_received <= 1'b1;
                if (state == READ_DATA) rd_addr_received <= 1'b0;
              end
            end else if (state == READ_DATA) begin
              // tx_cnt: 0 = waiting for RAM, 1..MEM_WIDTH = shifting, MEM_WIDTH+1 = done
              if (tx_cnt == '0) begin
                if (tx_valid) begin
                  MISO     <= tx_data[MEM_WIDTH-1];
                  tx_shift <= {tx_data[MEM_WIDTH-2:0], 1'b0};
                  tx_cnt   <= TW'(1);
                end
              end else if (tx_cnt < TW'(MEM_WIDTH)) begin
                MISO     <= tx_shift[MEM_WIDTH-1];
                tx_shift <= {tx_shift[MEM_WIDTH-2:0], 1'b0};
                tx_cnt   <= tx_cnt + TW'(1);
              end else if (tx_cnt == TW'(MEM_WIDTH)) begin
                MISO   <= 1'b0;
                tx_cnt <= TW'(MEM_WIDTH + 1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed table-driven bench for spi_slave_ctrl: frames, read-back, aborts, resets.
module tb_spi_slave_ctrl;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks = 0;
  int errors = 0;

  spi_slave_ctrl #(.MEM_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] frame;
    int         ss_edges;   // posedges with SS_n low, including edge 0
    logic       extra;      // MOSI value after the 10th bit
    logic       tx_en;      // pulse tx_valid before edges 5 and 12
    logic [7:0] ram;
    int         rst_edge;   // assert rst_n just after this edge, -1 = none
    int         exp_pulses;
    logic [9:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         pulses;
    int         pulse_edge;
    int         stray;
    logic [9:0] cap;
    logic [7:0] miso_got;
    logic       did_rst;
    pulses = 0; pulse_edge = -1; stray = 0; cap = '0; miso_got = '0; did_rst = 1'b0;
    for (int e = 0; e < v.ss_edges; e++) begin
      SS_n     = 1'b0;
      MOSI     = (e >= 1 && e <= 10) ? v.frame[10-e] : v.extra;
      tx_valid = v.tx_en && (e == 5 || e == 12);
      tx_data  = v.ram;
      @(posedge clk); #1;
      if (rx_valid) begin
        pulses++;
        if (pulse_edge < 0) pulse_edge = e;
        cap = rx_data;
      end
      if (e >= 12 && e <= 19) miso_got[19-e] = MISO;
      else if (MISO !== 1'b0) stray++;
      if (e == v.rst_edge) begin
        #2 rst_n = 1'b0;
        #1;
        check($sformatf("v%0d rst MISO", idx), 32'(MISO), 32'd0);
        check($sformatf("v%0d rst rx_valid", idx), 32'(rx_valid), 32'd0);
        check($sformatf("v%0d rst rx_data", idx), 32'(rx_data), 32'd0);
        did_rst = 1'b1;
        break;
      end
    end
    SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0;
    if (did_rst) begin
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      check($sformatf("v%0d pulses", idx), 32'(pulses), 32'(v.exp_pulses));
      if (v.exp_pulses > 0) begin
        check($sformatf("v%0d rx_data", idx), 32'(cap), 32'(v.exp_rx));
        check($sformatf("v%0d rx_valid edge", idx), 32'(pulse_edge), 32'd10);
      end
      check($sformatf("v%0d miso byte", idx), 32'(miso_got), 32'(v.exp_miso));
      check($sformatf("v%0d miso stray", idx), 32'(stray), 32'd0);
      check($sformatf("v%0d idle MISO", idx), 32'(MISO), 32'd0);
      check($sformatf("v%0d idle rx_valid", idx), 32'(rx_valid), 32'd0);
    end
  endtask

  initial begin
    //           frame   ss  ext  tx    ram  rst pul  exp_rx  miso
    vecs[0]  = '{10'h0A5, 11, 1'b0, 1'b0, 8'h00, -1, 1, 10'h0A5, 8'h00};
    vecs[1]  = '{10'h13C, 11, 1'b1, 1'b0, 8'h00, -1, 1, 10'h13C, 8'h00};
    vecs[2]  = '{10'h242, 11, 1'b0, 1'b0, 8'h00, -1, 1, 10'h242, 8'h00};
    vecs[3]  = '{10'h300, 21, 1'b0, 1'b1, 8'hC3, -1, 1, 10'h300, 8'hC3};
    vecs[4]  = '{10'h2FF,  7, 1'b0, 1'b0, 8'h00, -1, 0, 10'h000, 8'h00};
    vecs[5]  = '{10'h255, 11, 1'b0, 1'b0, 8'h00, -1, 1, 10'h255, 8'h00};
    vecs[6]  = '{10'h3FF,  7, 1'b0, 1'b1, 8'hFF, -1, 0, 10'h000, 8'h00};
    vecs[7]  = '{10'h3AA, 21, 1'b0, 1'b1, 8'h5A, -1, 1, 10'h3AA, 8'h5A};
    vecs[8]  = '{10'h3AA, 21, 1'b0, 1'b1, 8'h81, -1, 1, 10'h3AA, 8'h00};
    vecs[9]  = '{10'h0F0, 15, 1'b1, 1'b0, 8'h00, -1, 1, 10'h0F0, 8'h00};
    vecs[10] = '{10'h055, 21, 1'b0, 1'b1, 8'hFF, -1, 1, 10'h055, 8'h00};
    vecs[11] = '{10'h1AB, 11, 1'b0, 1'b0, 8'h00, -1, 1, 10'h1AB, 8'h00};
    vecs[12] = '{10'h3E7, 21, 1'b0, 1'b1, 8'h96, -1, 1, 10'h3E7, 8'h96};
    vecs[13] = '{10'h0A5, 11, 1'b0, 1'b0, 8'h00,  5, 0, 10'h000, 8'h00};
    vecs[14] = '{10'h242, 11, 1'b0, 1'b0, 8'h00, -1, 1, 10'h242, 8'h00};
    vecs[15] = '{10'h3FF, 21, 1'b0, 1'b1, 8'hFF, 13, 0, 10'h000, 8'h00};
    vecs[16] = '{10'h3C3, 21, 1'b0, 1'b1, 8'h81, -1, 1, 10'h3C3, 8'h00};
    vecs[17] = '{10'h0A5, 11, 1'b0, 1'b0, 8'h00, -1, 1, 10'h0A5, 8'h00};

    rst_n = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset MISO", 32'(MISO), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave front end that deserialises 10-bit MOSI frames into the single-port RAM's command word and serialises RAM read data back out on MISO. It sits directly upstream of the SPI RAM: it drives the RAM's `din`/`rx_valid` and consumes its `dout`/`tx_valid`. The block is a five-state FSM with shift registers and bit counters, clocked by the SPI clock.

## Interface
- `MEM_WIDTH`, 8, RAM data width; the command frame is `MEM_WIDTH+2` bits and read data is `MEM_WIDTH` bits.
- `clk` input 1: SPI clock; all sampling and launching happen on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `SS_n` input 1: active-low slave select; high means the bus is idle or the frame is aborted.
- `MOSI` input 1: serial data in, MSB first.
- `MISO` output 1: serial data out, MSB first; registered.
- `rx_data` output `MEM_WIDTH+2`: command word to RAM `din`; `[9:8]` are control bits, `[7:0]` are address/data.
- `rx_valid` output 1: one-cycle strobe marking `rx_data` as valid.
- `tx_data` input `MEM_WIDTH`: RAM `dout`.
- `tx_valid` input 1: RAM read-data-valid strobe.

## Operation
- States:
  - IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - Internal flag `rd_addr_received`.
- Reset (async, `rst_n`=0):
  - Every output and register is forced: state=IDLE, `rx_data`=0, `rx_valid`=0, `MISO`=0, bit counters=0, `rd_addr_received`=0.
  - The reset takes effect immediately, including mid-frame.
- Abort: in any state, `SS_n`=1 at a posedge sends the next state to IDLE.
  - Partial frames are discarded: no `rx_valid`, counters cleared, `MISO` driven 0.
  - `rd_addr_received` is unchanged.
- IDLE: if `SS_n`=0, go to CHK_CMD.
- CHK_CMD: samples MOSI as frame bit 9 (shift register bit 0, count=1).
  - MOSI=0 → WRITE.
  - MOSI=1 and !`rd_addr_received` → READ_ADD.
  - MOSI=1 and `rd_addr_received` → READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Bits 8..0 are shifted in MSB first, one per posedge.
  - On the posedge that samples bit 0 (the 10th bit), `rx_data` <= full frame and `rx_valid` <= 1 for exactly one cycle.
- Frame bits are forwarded verbatim. The block does not check `[8]` or correct mismatched control bits; the RAM decodes them.
- READ_ADD completion (the `rx_valid` edge) sets `rd_addr_received`.
- READ_DATA completion (the `rx_valid` edge) clears `rd_addr_received`, then the block waits for `tx_valid`.
- READ_DATA transmit phase:
  - On the first posedge with `tx_valid`=1, `tx_data` is latched and `MISO` <= `tx_data[7]`.
  - The next 7 posedges drive bits 6..0.
  - After bit 0, `MISO` <= 0 and the block holds until `SS_n`=1.
- `tx_valid` outside the READ_DATA wait window is ignored.
- Extra MOSI bits after the 10th are ignored in every state. The block stays in its state, with no second `rx_valid`, until `SS_n` rises.
- Back-to-back frames require `SS_n`=1 for ≥1 posedge between them.

## Timing
- Edge numbering: edge 0 is the first posedge with `SS_n`=0, which moves IDLE→CHK_CMD.
- Edges 1..10 sample frame bits 9..0. `rx_valid`=1 in the cycle after edge 10 and deasserts after edge 11.
- RAM latency: `tx_valid` is expected after edge 11 (RAM samples `rx_valid` at edge 11).
- Slave samples `tx_valid` at edge 12. `MISO` carries bit 7 after edge 12, bits 6..0 after edges 13..19, and 0 after edge 20.
- Minimum `SS_n`-low time:
  - Write or read-address frame: 11 edges.
  - Read-data frame: 21 edges.
- `rx_valid` is never high for two consecutive cycles.
- `rx_valid` is never asserted while `SS_n` was high at the generating edge.
- Reset deassertion: the first active edge after `rst_n` rises may accept `SS_n`=0.

## Test plan
- Reset mid-frame: assert `rst_n`=0 at edge 5 of a write frame → `MISO`=0, `rx_valid`=0, `rx_data`=0 immediately; the next frame decodes normally.
- Write address then data: frames 0x0A5 then 0x13C → `rx_valid` pulses once per frame with `rx_data`=0x0A5 and then 0x13C; `MISO` stays 0.
- Read sequence: frame 0x242 → `rx_data`=0x242, flag set. Frame 0x300 with RAM returning 0xC3 → `MISO` bits 1,1,0,0,0,0,1,1 after edges 12..19, then flag cleared.
- Abort: `SS_n` raised after 6 bits of a read-address frame → no `rx_valid`, state IDLE, flag unchanged. The next 10-bit frame starting with 1 still enters READ_ADD.
- Overlong frame: 14 bits clocked with `SS_n` low on a write frame → exactly one `rx_valid`, carrying the first 10 bits.
- Spurious `tx_valid`=1 during a WRITE frame → `MISO` remains 0 and the latched `tx_data` is unaffected.
